// File: rtl/rm_symbol_sequencer.sv
// rm_symbol_sequencer
//
// Producer end of the runtime-monitor symbol interface. Trace events from the
// core arrive on a valid/ready port and are buffered in a small FIFO; the
// sequencer then streams them to the monitor cluster at one symbol per cycle
// and runs a monitor reset sequence at power-up and after every end-of-trace
// symbol, so each trace is checked from the automata start states.
//
// Optional feature (macro RM_SEQ_IDLE_FILL_EN): while streaming with enable
// high and nothing buffered, the sequencer emits IDLE_SYM with run=1 instead
// of idling. The IDLE_SYM parameter only exists in that build.
//
// Parameters
//   SYM_W       symbol width, matches the monitor symbols input
//   DEPTH       FIFO entries, power of two, >= 2
//   RST_CYCLES  cycles mon_reset is held high per reset sequence, >= 1
//   IDLE_SYM    filler symbol (RM_SEQ_IDLE_FILL_EN builds only)
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   enable     allows popping toward the monitor
//   ev_valid   event valid
//   ev_ready   FIFO can accept an event (registered)
//   ev_symbol  event symbol
//   ev_last    final symbol of a trace
//   symbols    registered symbol to the monitor
//   run        registered, monitor consumes symbols this cycle
//   mon_reset  registered, active-high monitor reset
//   busy       FIFO non-empty or not streaming
//   trace_len  symbols emitted in the current trace, wraps at 2^16
//
// FSM states
//   state     | meaning
//   ST_MRST   | monitor reset sequence; mon_reset held, no popping
//   ST_STREAM | popping buffered events toward the monitor

module rm_symbol_sequencer #(
    parameter int SYM_W      = 8,
    parameter int DEPTH      = 8,
    parameter int RST_CYCLES = 2
`ifdef RM_SEQ_IDLE_FILL_EN
    ,
    parameter logic [SYM_W-1:0] IDLE_SYM = '0
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             ev_valid,
    output logic             ev_ready,
    input  logic [SYM_W-1:0] ev_symbol,
    input  logic             ev_last,
    output logic [SYM_W-1:0] symbols,
    output logic             run,
    output logic             mon_reset,
    output logic             busy,
    output logic [15:0]      trace_len
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_C    = (AW+1)'(1);
    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);

    typedef enum logic {
        ST_MRST   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t state, state_nxt;
    logic [CW-1:0] rst_cnt, rst_cnt_nxt;

    // FIFO entry is {last, symbol}
    logic [SYM_W:0]  mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count, count_nxt;
    logic            empty;
    logic            push, pop;
    logic [SYM_W:0]  head;

    logic [SYM_W-1:0] symbols_nxt;
    logic             run_nxt;
    logic             mon_reset_nxt;
    logic [15:0]      trace_len_nxt;

    assign empty = (count == '0);
    assign head  = mem[rd_ptr];
    assign push  = ev_valid && ev_ready;
    assign busy  = !empty || (state != ST_STREAM);

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + ONE_C;
        end else if (!push && pop) begin
            count_nxt = count - ONE_C;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {ev_last, ev_symbol};
        end
    end

    // ev_ready is registered from the next occupancy, so a same-cycle pop at
    // full never re-opens the port combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ev_ready <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count    <= count_nxt;
            ev_ready <= (count_nxt != DEPTH_C);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_MRST;
            rst_cnt   <= '0;
            symbols   <= '0;
            run       <= 1'b0;
            mon_reset <= 1'b1;
            trace_len <= '0;
        end else begin
            state     <= state_nxt;
            rst_cnt   <= rst_cnt_nxt;
            symbols   <= symbols_nxt;
            run       <= run_nxt;
            mon_reset <= mon_reset_nxt;
            trace_len <= trace_len_nxt;
        end
    end

    // rst_cnt only advances on cycles where mon_reset is actually visible.
    // At power-up mon_reset is high straight out of reset; after an
    // end-of-trace pop the first MRST cycle still shows the last symbol, so
    // that cycle is not counted and the monitor always sees RST_CYCLES
    // cycles of mon_reset.
    always_comb begin
        state_nxt     = state;
        rst_cnt_nxt   = rst_cnt;
        pop           = 1'b0;
        symbols_nxt   = symbols;
        run_nxt       = 1'b0;
        mon_reset_nxt = mon_reset;
        trace_len_nxt = trace_len;
        case (state)
            ST_MRST: begin
                symbols_nxt   = '0;
                trace_len_nxt = '0;
                if (mon_reset && (rst_cnt == RST_LAST)) begin
                    state_nxt     = ST_STREAM;
                    rst_cnt_nxt   = '0;
                    mon_reset_nxt = 1'b0;
                end else begin
                    mon_reset_nxt = 1'b1;
                    if (mon_reset) begin
                        rst_cnt_nxt = rst_cnt + 1'b1;
                    end
                end
            end
            ST_STREAM: begin
                mon_reset_nxt = 1'b0;
                if (enable && !empty) begin
                    pop           = 1'b1;
                    symbols_nxt   = head[SYM_W-1:0];
                    run_nxt       = 1'b1;
                    trace_len_nxt = trace_len + 16'd1;
                    if (head[SYM_W]) begin
                        state_nxt   = ST_MRST;
                        rst_cnt_nxt = '0;
                    end
                end
`ifdef RM_SEQ_IDLE_FILL_EN
                else if (enable) begin
                    symbols_nxt   = IDLE_SYM;
                    run_nxt       = 1'b1;
                    trace_len_nxt = trace_len + 16'd1;
                end
`endif
            end
            default: begin
                state_nxt = ST_MRST;
            end
        endcase
    end

endmodule
